// File: rtl/rename_free_pool.sv
// Physical-register free pool for rename: N-wide all-or-nothing allocation, M-wide release,
// and a circular FIFO of branch checkpoints. Optional double-free detection: RENAME_FREE_POOL_DBL_FREE_CHECK_EN.
module rename_free_pool #(
  parameter int PHYS_REGS   = 64,
  parameter int ARCH_REGS   = 32,
  parameter int ALLOC_PORTS = 4,
  parameter int FREE_PORTS  = 4,
  parameter int CKPTS       = 4,
  parameter int PW          = $clog2(PHYS_REGS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ALLOC_PORTS-1:0]         alloc_req,
  output logic [ALLOC_PORTS*PW-1:0]      alloc_phys,
  output logic [ALLOC_PORTS-1:0]         alloc_valid,
  output logic                           alloc_stall,
  input  logic [FREE_PORTS-1:0]          free_en,
  input  logic [FREE_PORTS*PW-1:0]       free_phys,
  input  logic                           ckpt_take,
  output logic [$clog2(CKPTS)-1:0]       ckpt_id,
  output logic                           ckpt_full,
  input  logic                           ckpt_release,
  input  logic                           restore_en,
  input  logic [$clog2(CKPTS)-1:0]       restore_id,
  output logic [$clog2(PHYS_REGS+1)-1:0] free_count,
  output logic                           dbl_free_err
);

  localparam int CIW = $clog2(CKPTS);
  localparam int KCW = $clog2(CKPTS + 1);
  localparam int NW  = $clog2(PHYS_REGS + 1);
  localparam logic [PHYS_REGS-1:0] RESET_MASK =
    {{(PHYS_REGS - ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};

  logic [PHYS_REGS-1:0]      free_mask_q, free_mask_d;
  logic [PHYS_REGS-1:0]      since_mask_q [CKPTS];
  logic [PHYS_REGS-1:0]      since_mask_d [CKPTS];
  logic [CKPTS-1:0]          ckpt_valid_q, ckpt_valid_d;
  logic [CIW-1:0]            head_q, head_d;
  logic [CIW-1:0]            tail_q, tail_d;
  logic [KCW-1:0]            count_q, count_d;
  logic [ALLOC_PORTS*PW-1:0] alloc_phys_q, alloc_phys_d;
  logic [ALLOC_PORTS-1:0]    alloc_valid_q, alloc_valid_d;
  logic                      alloc_stall_q, alloc_stall_d;
  logic [NW-1:0]             free_count_q, free_count_d;

  // Working copies for the per-cycle update sequence.
  logic [PHYS_REGS-1:0]      work;
  logic [PHYS_REGS-1:0]      granted;
  logic [NW-1:0]             req_cnt;
  logic [NW-1:0]             avail_cnt;
  logic [CIW-1:0]            roff;
  logic [CIW-1:0]            offs;
  logic                      found;

  function automatic logic [NW-1:0] count_ones(input logic [PHYS_REGS-1:0] v);
    logic [NW-1:0] n;
    n = '0;
    for (int i = 0; i < PHYS_REGS; i++) n = n + NW'(v[i]);
    return n;
  endfunction

  // NOTE: every variable is given a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    work          = free_mask_q;
    granted       = '0;
    req_cnt       = '0;
    avail_cnt     = '0;
    roff          = '0;
    offs          = '0;
    found         = 1'b0;
    since_mask_d  = since_mask_q;
    ckpt_valid_d  = ckpt_valid_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    alloc_phys_d  = '0;
    alloc_valid_d = '0;
    alloc_stall_d = 1'b0;

    // NOTE: blocking assignments here are deliberate; each step must see the
    // result of the previous one within the same cycle.
    for (int j = 0; j < FREE_PORTS; j++) begin
      if (free_en[j]) work[free_phys[j*PW +: PW]] = 1'b1;
    end

    if (restore_en) begin
      // Only a live checkpoint carries a meaningful since-mask and FIFO position.
      if (ckpt_valid_q[restore_id]) begin
        work = work | since_mask_q[restore_id];
        roff = restore_id - head_q;
        for (int i = 0; i < CKPTS; i++) begin
          offs = CIW'(i) - head_q;
          if (offs >= roff) ckpt_valid_d[i] = 1'b0;
        end
        count_d = KCW'(roff);
        tail_d  = restore_id;
      end
    end else begin
      for (int k = 0; k < ALLOC_PORTS; k++) req_cnt = req_cnt + NW'(alloc_req[k]);
      avail_cnt = count_ones(work);
      if (req_cnt > avail_cnt) begin
        alloc_stall_d = 1'b1;
      end else begin
        // Ascending ports take ascending free tags.
        for (int k = 0; k < ALLOC_PORTS; k++) begin
          if (alloc_req[k]) begin
            found = 1'b0;
            for (int b = 0; b < PHYS_REGS; b++) begin
              if (!found && work[b]) begin
                found                   = 1'b1;
                work[b]                 = 1'b0;
                granted[b]              = 1'b1;
                alloc_phys_d[k*PW +: PW] = PW'(b);
                alloc_valid_d[k]        = 1'b1;
              end
            end
          end
        end
      end
    end

    // Grants belong to every open checkpoint; a slot opened below starts clean.
    for (int i = 0; i < CKPTS; i++) begin
      if (ckpt_valid_q[i]) since_mask_d[i] = since_mask_q[i] | granted;
    end

    if (!restore_en && ckpt_take && (count_q != KCW'(CKPTS))) begin
      since_mask_d[tail_q] = '0;
      ckpt_valid_d[tail_q] = 1'b1;
      tail_d               = tail_q + CIW'(1);
      count_d              = count_d + KCW'(1);
    end

    if (ckpt_release && ckpt_valid_d[head_q]) begin
      ckpt_valid_d[head_q] = 1'b0;
      head_d               = head_q + CIW'(1);
      count_d              = count_d - KCW'(1);
    end

    free_mask_d  = work;
    free_count_d = count_ones(work);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      free_mask_q   <= RESET_MASK;
      ckpt_valid_q  <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      alloc_phys_q  <= '0;
      alloc_valid_q <= '0;
      alloc_stall_q <= 1'b0;
      free_count_q  <= NW'(PHYS_REGS - ARCH_REGS);
    end else begin
      free_mask_q   <= free_mask_d;
      ckpt_valid_q  <= ckpt_valid_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      alloc_phys_q  <= alloc_phys_d;
      alloc_valid_q <= alloc_valid_d;
      alloc_stall_q <= alloc_stall_d;
      free_count_q  <= free_count_d;
    end
  end

  // NOTE: the since-masks carry no reset; a slot is cleared when taken and is
  // only read or accumulated while valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    since_mask_q <= since_mask_d;
  end

`ifdef RENAME_FREE_POOL_DBL_FREE_CHECK_EN
  logic dbl_hit;
  logic dbl_free_err_q;

  // Flags a release of an already-free tag or one tag on two ports at once.
  always_comb begin
    dbl_hit = 1'b0;
    for (int j = 0; j < FREE_PORTS; j++) begin
      if (free_en[j]) begin
        if (free_mask_q[free_phys[j*PW +: PW]]) dbl_hit = 1'b1;
        for (int m = j + 1; m < FREE_PORTS; m++) begin
          if (free_en[m] && (free_phys[m*PW +: PW] == free_phys[j*PW +: PW])) dbl_hit = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        dbl_free_err_q <= 1'b0;
    else if (dbl_hit) dbl_free_err_q <= 1'b1;
  end

  assign dbl_free_err = dbl_free_err_q;
`else
  assign dbl_free_err = 1'b0;
`endif

  assign alloc_phys  = alloc_phys_q;
  assign alloc_valid = alloc_valid_q;
  assign alloc_stall = alloc_stall_q;
  assign free_count  = free_count_q;
  assign ckpt_id     = tail_q;
  assign ckpt_full   = (count_q == KCW'(CKPTS));

endmodule
